// File: rtl/enemy_pkg.sv
// Shared types and screen constants for the enemy wave-group logic.
package enemy_pkg;
  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    ENTER,
    HOLD,
    DIVE,
    EXPLODE
  } slot_state_t;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_BOTTOM = 480;
endpackage

// File: rtl/enemy_slot.sv
// One ship slot: motion FSM, position registers and explosion timer.
// state   | meaning
// IDLE    | slot empty
// ENTER   | descending to formation row
// HOLD    | parked in formation, eligible to shoot
// DIVE    | diving toward the bottom of the screen
// EXPLODE | frozen, explosion frames playing
module enemy_slot
  import enemy_pkg::*;
#(
  parameter int K              = 0,
  parameter int SPAWN_X0       = 80,
  parameter int SPACING        = 120,
  parameter int ENTER_SPEED    = 2,
  parameter int HOLD_Y         = 120,
  parameter int FLYDOWN_SPEED  = 4,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rise,
  input  logic        flydown,
  input  logic        hit,
  output slot_state_t state,
  output coord_t      x,
  output coord_t      y,
  output logic        kill
);
  localparam int CW = (EXPLODE_FRAMES > 2) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam coord_t X_HOME = coord_t'(SPAWN_X0 + K * SPACING);

  slot_state_t   state_n;
  coord_t        x_n, y_n;
  logic          kill_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [10:0]   enter_sum, dive_sum;

  // 11-bit sums so a step past 1023 cannot wrap below the compare limits.
  assign enter_sum = {1'b0, y} + 11'(ENTER_SPEED);
  assign dive_sum  = {1'b0, y} + 11'(FLYDOWN_SPEED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      cnt   <= cnt_n;
      kill  <= kill_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    cnt_n   = cnt;
    kill_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = ENTER;
          x_n     = X_HOME;
          y_n     = '0;
        end
      end
      ENTER, HOLD: begin
        if (hit) begin
          state_n = EXPLODE;
          cnt_n   = CW'(EXPLODE_FRAMES - 1);
          kill_n  = 1'b1;
        end else if (flydown) begin
          state_n = DIVE;
        end else if (state == ENTER) begin
          if (enter_sum >= 11'(HOLD_Y)) begin
            state_n = HOLD;
            y_n     = coord_t'(HOLD_Y);
          end else begin
            y_n = enter_sum[9:0];
          end
        end
      end
      DIVE: begin
        if (hit) begin
          state_n = EXPLODE;
          cnt_n   = CW'(EXPLODE_FRAMES - 1);
          kill_n  = 1'b1;
        end else if (dive_sum >= 11'(SCREEN_BOTTOM)) begin
          state_n = IDLE;
          y_n     = '0;
        end else begin
          y_n = dive_sum[9:0];
        end
      end
      EXPLODE: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/enemy_squad.sv
// Four-slot enemy wave group: spawn edge detect, slot array, round-robin
// shot arbiter with a held request/ack handshake.
module enemy_squad
  import enemy_pkg::*;
#(
  parameter int SPAWN_X0       = 80,
  parameter int SPACING        = 120,
  parameter int ENTER_SPEED    = 2,
  parameter int HOLD_Y         = 120,
  parameter int FLYDOWN_SPEED  = 4,
  parameter int SHIP_W         = 32,
  parameter int SHIP_H         = 32,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [3:0]  spawn,
  input  logic        flydown,
  input  logic        enemy_shoot,
  input  logic [3:0]  hit,
  input  logic        shot_ack,
  output logic [3:0]  alive,
  output logic [3:0]  exploding,
  output logic [39:0] ship_x,
  output logic [39:0] ship_y,
  output logic        shot_req,
  output coord_t      shot_x,
  output coord_t      shot_y,
  output logic [3:0]  kill
);
  logic [3:0]  spawn_d, rise;
  logic        armed;
  slot_state_t st [4];
  coord_t      sx [4];
  coord_t      sy [4];
  logic [1:0]  rr_ptr, sel, idx;
  logic        found;

  // armed masks the first edge after reset so a level already high is not an edge.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      spawn_d <= '0;
      armed   <= 1'b0;
    end else begin
      spawn_d <= spawn;
      armed   <= 1'b1;
    end
  end

  assign rise = spawn & ~spawn_d & {4{armed}};

  for (genvar k = 0; k < 4; k++) begin : g_slot
    enemy_slot #(
      .K(k), .SPAWN_X0(SPAWN_X0), .SPACING(SPACING), .ENTER_SPEED(ENTER_SPEED),
      .HOLD_Y(HOLD_Y), .FLYDOWN_SPEED(FLYDOWN_SPEED), .EXPLODE_FRAMES(EXPLODE_FRAMES)
    ) u_slot (
      .clk(frame_clk), .rst(Reset), .rise(rise[k]), .flydown(flydown), .hit(hit[k]),
      .state(st[k]), .x(sx[k]), .y(sy[k]), .kill(kill[k])
    );
    assign alive[k]            = (st[k] == ENTER) || (st[k] == HOLD) || (st[k] == DIVE);
    assign exploding[k]        = (st[k] == EXPLODE);
    assign ship_x[10*k +: 10]  = sx[k];
    assign ship_y[10*k +: 10]  = sy[k];
  end

  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    idx   = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && st[idx] == HOLD) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      shot_req <= 1'b0;
      shot_x   <= '0;
      shot_y   <= '0;
      rr_ptr   <= '0;
    end else if (shot_req) begin
      if (shot_ack) shot_req <= 1'b0;
    end else if (enemy_shoot && found) begin
      shot_req <= 1'b1;
      shot_x   <= sx[sel] + coord_t'(SHIP_W / 2);
      shot_y   <= sy[sel] + coord_t'(SHIP_H);
      rr_ptr   <= sel + 2'd1;
    end
  end
endmodule

// File: tb/tb_enemy_squad.sv
// Self-checking bench for enemy_squad: per-scenario tasks, shot scoreboard.
module tb_enemy_squad;
  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  spawn = '0;
  logic        flydown = 1'b0;
  logic        enemy_shoot = 1'b0;
  logic [3:0]  hit = '0;
  logic        shot_ack = 1'b0;
  logic [3:0]  alive, exploding, kill;
  logic [39:0] ship_x, ship_y;
  logic        shot_req;
  logic [9:0]  shot_x, shot_y;

  int errors = 0;
  int checks = 0;
  logic [19:0] sb [$];

  enemy_squad dut (
    .frame_clk(frame_clk), .Reset(Reset), .spawn(spawn), .flydown(flydown),
    .enemy_shoot(enemy_shoot), .hit(hit), .shot_ack(shot_ack), .alive(alive),
    .exploding(exploding), .ship_x(ship_x), .ship_y(ship_y), .shot_req(shot_req),
    .shot_x(shot_x), .shot_y(shot_y), .kill(kill)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [9:0] ys(int k);
    return ship_y[10*k +: 10];
  endfunction

  function automatic logic [9:0] xs(int k);
    return ship_x[10*k +: 10];
  endfunction

  task automatic shoot_and_expect(input logic [9:0] ex, input logic [9:0] ey);
    bit ok;
    logic [19:0] exp_v;
    enemy_shoot = 1'b1;
    sb.push_back({ex, ey});
    tick();
    enemy_shoot = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (shot_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL shot_req_timeout got=%0b want=1", shot_req);
    end else if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checks++;
      if ({shot_x, shot_y} !== exp_v) begin
        errors++;
        $display("FAIL shot_xy got=%0d,%0d want=%0d,%0d", shot_x, shot_y, exp_v[19:10], exp_v[9:0]);
      end
    end
  endtask

  task automatic ack_shot();
    shot_ack = 1'b1;
    tick();
    shot_ack = 1'b0;
    checks++;
    if (shot_req !== 1'b0) begin
      errors++;
      $display("FAIL shot_ack_clear got=%0b want=0", shot_req);
    end
  endtask

  task automatic test_reset();
    spawn = 4'b1000;
    tick();
    tick();
    checks++;
    if ({alive, exploding, kill, shot_req} !== 13'd0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0", {alive, exploding, kill, shot_req});
    end
    checks++;
    if ({ship_x, ship_y, shot_x, shot_y} !== 100'd0) begin
      errors++;
      $display("FAIL reset_coords got_x=%h got_y=%h want=0", ship_x, ship_y);
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (alive !== 4'b0000) begin
      errors++;
      $display("FAIL spawn_held_reset got=%b want=0000", alive);
    end
    spawn = 4'b0000;
    tick();
  endtask

  task automatic test_enter();
    logic [9:0] want;
    spawn = 4'b0001;
    tick();
    spawn = 4'b0000;
    checks++;
    if (alive !== 4'b0001 || xs(0) !== 10'd80 || ys(0) !== 10'd0) begin
      errors++;
      $display("FAIL enter_first got alive=%b x=%0d y=%0d want 0001 80 0", alive, xs(0), ys(0));
    end
    for (int m = 2; m <= 62; m++) begin
      tick();
      want = (m >= 61) ? 10'd120 : 10'(2 * (m - 1));
      checks++;
      if (ys(0) !== want || alive !== 4'b0001) begin
        errors++;
        $display("FAIL enter_y frame=%0d got=%0d want=%0d alive=%b", m, ys(0), want, alive);
      end
    end
  endtask

  task automatic test_dive();
    int n;
    bit saw_kill;
    logic [9:0] last_y;
    spawn = 4'b1111;
    tick();
    spawn = 4'b0000;
    for (int i = 0; i < 62; i++) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ys(k) !== 10'd120 || xs(k) !== 10'(80 + 120 * k)) begin
        errors++;
        $display("FAIL hold_pos slot=%0d got=%0d,%0d want=%0d,120", k, xs(k), ys(k), 80 + 120 * k);
      end
    end
    flydown = 1'b1;
    tick();
    flydown = 1'b0;
    tick();
    n = 1;
    checks++;
    if (ys(0) !== 10'd124 || ys(3) !== 10'd124 || alive !== 4'b1111) begin
      errors++;
      $display("FAIL dive_first got y0=%0d y3=%0d alive=%b want 124 124 1111", ys(0), ys(3), alive);
    end
    saw_kill = 1'b0;
    last_y = ys(0);
    while (alive !== 4'b0000 && n < 200) begin
      last_y = ys(0);
      tick();
      n++;
      if (kill !== 4'b0000) saw_kill = 1'b1;
    end
    checks++;
    if (n !== 90 || last_y !== 10'd476) begin
      errors++;
      $display("FAIL dive_retire got frames=%0d last_y=%0d want 90 476", n, last_y);
    end
    checks++;
    if (saw_kill) begin
      errors++;
      $display("FAIL dive_kill got=1 want=0");
    end
    enemy_shoot = 1'b1;
    tick();
    enemy_shoot = 1'b0;
    tick();
    checks++;
    if (shot_req !== 1'b0) begin
      errors++;
      $display("FAIL shoot_none_hold got=%0b want=0", shot_req);
    end
  endtask

  task automatic test_hit();
    int n;
    bit extra_kill;
    spawn = 4'b0100;
    tick();
    spawn = 4'b0000;
    for (int i = 0; i < 62; i++) tick();
    hit = 4'b0100;
    tick();
    hit = 4'b0000;
    checks++;
    if (kill !== 4'b0100 || exploding !== 4'b0100 || alive !== 4'b0000 || ys(2) !== 10'd120) begin
      errors++;
      $display("FAIL hit_explode got kill=%b expl=%b alive=%b y=%0d want 0100 0100 0000 120",
               kill, exploding, alive, ys(2));
    end
    hit = 4'b0100;
    tick();
    hit = 4'b0000;
    n = 2;
    checks++;
    if (kill !== 4'b0000) begin
      errors++;
      $display("FAIL second_hit_kill got=%b want=0000", kill);
    end
    extra_kill = 1'b0;
    while (exploding[2] === 1'b1 && n < 100) begin
      tick();
      if (kill !== 4'b0000) extra_kill = 1'b1;
      if (exploding[2] === 1'b1) n++;
    end
    checks++;
    if (n !== 16 || extra_kill) begin
      errors++;
      $display("FAIL explode_len got=%0d extra_kill=%0b want=16 0", n, extra_kill);
    end
    tick();
    checks++;
    if (alive[2] !== 1'b0 || exploding[2] !== 1'b0) begin
      errors++;
      $display("FAIL after_explode got alive=%b expl=%b want 0 0", alive[2], exploding[2]);
    end
  endtask

  task automatic test_shot();
    spawn = 4'b0101;
    tick();
    spawn = 4'b0000;
    for (int i = 0; i < 62; i++) tick();
    shoot_and_expect(10'd96, 10'd152);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) enemy_shoot = 1'b1;
      tick();
      enemy_shoot = 1'b0;
      checks++;
      if (shot_req !== 1'b1 || shot_x !== 10'd96 || shot_y !== 10'd152) begin
        errors++;
        $display("FAIL shot_hold i=%0d got req=%0b xy=%0d,%0d want 1 96,152", i, shot_req, shot_x, shot_y);
      end
    end
    ack_shot();
    shoot_and_expect(10'd336, 10'd152);
    ack_shot();
    shoot_and_expect(10'd96, 10'd152);
    ack_shot();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_hit_vs_flydown();
    spawn = 4'b0010;
    tick();
    spawn = 4'b0000;
    for (int i = 0; i < 62; i++) tick();
    hit = 4'b0010;
    flydown = 1'b1;
    tick();
    hit = 4'b0000;
    flydown = 1'b0;
    checks++;
    if (kill !== 4'b0010 || exploding !== 4'b0010 || alive !== 4'b0101) begin
      errors++;
      $display("FAIL hit_beats_flydown got kill=%b expl=%b alive=%b want 0010 0010 0101",
               kill, exploding, alive);
    end
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    tick();
    spawn = 4'b0001;
    tick();
    spawn = 4'b0000;
    for (int i = 0; i < 62; i++) tick();
    shoot_and_expect(10'd96, 10'd152);
    flydown = 1'b1;
    tick();
    flydown = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (alive !== 4'b0001 || shot_req !== 1'b1 || ys(0) !== 10'd140) begin
      errors++;
      $display("FAIL pre_reset got alive=%b req=%0b y=%0d want 0001 1 140", alive, shot_req, ys(0));
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({alive, exploding, shot_req} !== 9'd0 || {ship_x, ship_y, shot_x, shot_y} !== 100'd0) begin
      errors++;
      $display("FAIL async_reset got alive=%b expl=%b req=%0b x=%h y=%h", alive, exploding, shot_req, ship_x, ship_y);
    end
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enter();
    test_dive();
    test_hit();
    test_shot();
    test_hit_vs_flydown();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/enemy_squad.md
Name: enemy_squad

Overview:
- Consumer side of the wave-controller interface: one instance owns the four ship slots of one wave group.
- Turns the controller's per-ship spawn levels, flydown pulse and enemy_shoot pulse into ship motion, an alive status and shot requests.
- Sits between the wave controller and the sprite, collision and enemy-projectile logic.
- Its alive outputs feed back into the controller's per-enemy alive inputs, which the controller uses to shorten flydown.

Parameters:
SPAWN_X0, 80, x of slot 0 (pixels)
SPACING, 120, x offset between adjacent slots
ENTER_SPEED, 2, pixels per frame descending to formation
HOLD_Y, 120, formation row y
FLYDOWN_SPEED, 4, pixels per frame while diving
SCREEN_BOTTOM, 480, y at which a diving ship is retired
SHIP_W, 32, ship width; SHIP_H, 32, ship height
EXPLODE_FRAMES, 16, frames spent in the explosion state

Ports:
frame_clk  in  1  frame-rate clock; all logic is on posedge
Reset  in  1  asynchronous, active-high
spawn  in  4  per-slot spawn levels from the wave controller; the rising edge is the event
flydown  in  1  one-frame pulse: formation dives
enemy_shoot  in  1  one-frame pulse, period 32 frames
hit  in  4  per-slot collision hit from the collision unit, one frame
shot_ack  in  1  projectile unit accepts the request
alive  out  4  slot is in ENTER, HOLD or DIVE
exploding  out  4  slot is in EXPLODE (sprite selects the explosion frames)
ship_x  out  40  packed, 10 bits per slot, slot k at bits [10k+9:10k]
ship_y  out  40  packed, same layout
shot_req  out  1  shot request, held until acked
shot_x  out  10  shot origin x
shot_y  out  10  shot origin y
kill  out  4  one-frame pulse when a slot enters EXPLODE

Behaviour:
- Reset (async): all slots IDLE; spawn_d=0; rr_ptr=0.
  - Outputs: alive=0, exploding=0, kill=0, ship_x=0, ship_y=0, shot_req=0, shot_x=0, shot_y=0.
- Edge detect: spawn_d <= spawn; rise[k] = spawn[k] & ~spawn_d[k].
  - A spawn level already high when Reset releases does not spawn.
- Slot FSM, states IDLE, ENTER, HOLD, DIVE, EXPLODE:
  - IDLE: on rise[k], go to ENTER next frame with x=SPAWN_X0+k*SPACING, y=0. Because all outputs are registered, alive[k]=1 one frame after the edge is sampled.
  - ENTER: if y+ENTER_SPEED >= HOLD_Y, set y=HOLD_Y and go to HOLD; otherwise y += ENTER_SPEED.
  - HOLD: hold position.
  - DIVE: entered from ENTER or HOLD on flydown. y += FLYDOWN_SPEED each frame. If y+FLYDOWN_SPEED >= SCREEN_BOTTOM, go to IDLE (alive=0, y=0, no kill).
  - EXPLODE: entered from ENTER, HOLD or DIVE on hit[k]. Position is frozen, kill[k]=1 for that single frame, and a counter loads EXPLODE_FRAMES-1. The counter decrements, and the slot goes to IDLE when it reaches 0 (EXPLODE_FRAMES frames in total).
  - Priorities:
    - A rise in any state other than IDLE is ignored.
    - A hit in IDLE or EXPLODE is ignored.
    - A hit and flydown in the same frame: hit wins.
    - Flydown while in IDLE, DIVE or EXPLODE: no effect.
- Arithmetic: all coordinates are 10-bit unsigned. Comparisons are made on the 11-bit sum so that a sum of 1023 or more cannot wrap.
- Shot arbiter:
  - Fires on enemy_shoot when shot_req=0.
  - Scans slots rr_ptr, rr_ptr+1, … mod 4 and takes the first slot in HOLD.
  - Latches shot_x = x+SHIP_W/2 and shot_y = y+SHIP_H, and sets shot_req=1 on the next edge.
  - Sets rr_ptr = selected+1 mod 4.
  - No slot in HOLD: no request, rr_ptr unchanged.
  - enemy_shoot while shot_req=1: dropped, not queued.
  - Handshake: shot_req clears on the edge after shot_ack is sampled high. shot_x and shot_y are stable while shot_req=1. shot_ack while shot_req=0 is ignored.
  - The shooter dying while its request is pending does not cancel the request.
- Reset asserted mid-dive, mid-explosion or mid-request returns everything to the reset values immediately.

Decomposition:
- Package enemy_pkg:
  - slot_state_t enum (IDLE, ENTER, HOLD, DIVE, EXPLODE)
  - screen constants SCREEN_W=640 and SCREEN_BOTTOM=480
  - coord_t = logic [9:0]
- Sub-module enemy_slot:
  - Contains one slot FSM, its position registers and the explosion counter.
  - Instantiated 4x with slot index k as a parameter.
  - Inputs: rise, flydown, hit.
  - Outputs: state, x, y, kill.
- The top level holds edge detect, shot arbiter and output packing.

Test Plan:
1. Reset, then spawn=0001 rising at frame 0 → alive=0001 at frame 1, ship_x[9:0]=80, y steps 0,2,4…, state HOLD with y=120 at frame 61.
2. All four slots spawned and held, then a flydown pulse → all four in DIVE, y=124 next frame. Each is retired (alive=0) on the frame its next step would reach 480 (y=476), 90 frames after the pulse, with no kill pulse.
3. hit=0100 while slot 2 is in HOLD → kill=0100 for one frame, exploding[2]=1 for 16 frames, then alive[2] and exploding[2] stay 0. A second hit during EXPLODE produces no second kill.
4. Slots 0 and 2 in HOLD, rr_ptr=0, enemy_shoot → shot_req=1 with shot_x=96, shot_y=152. Hold shot_ack low for 40 frames: a second enemy_shoot is dropped and the values stay stable. Ack → shot_req=0 next frame. Next enemy_shoot selects slot 2 (shot_x=336).
5. hit[1] and flydown in the same frame with slot 1 in HOLD → slot 1 goes to EXPLODE, not DIVE. spawn[3] held high across Reset release → no spawn of slot 3.
6. Reset asserted mid-dive with shot_req=1 → on assertion alive=0, exploding=0, shot_req=0 and all coordinates 0, without waiting for a clock edge.
